// File: rtl/fpu_norm_arbiter.sv
// Round-robin arbiter and two-stage sequencer in front of the shared post-normalization datapath.
// Stage 1 feeds the normalizer, stage 2 holds its result for the downstream handshake.
module fpu_norm_arbiter #(
    parameter int FORMAT_LENGTH             = 32,
    parameter int EXPONENT_LENGTH           = 8,
    parameter int NORMALIZE_MANTISSA_LENGTH = 24,
    parameter int TAG_W                     = 4,
    parameter int CNT_W                     = 8
) (
    input  logic                                 clk,
    input  logic                                 rst_n,

    input  logic                                 a_valid,
    output logic                                 a_ready,
    input  logic                                 a_sign,
    input  logic                                 a_cout,
    input  logic [EXPONENT_LENGTH-1:0]           a_exp,
    input  logic [NORMALIZE_MANTISSA_LENGTH-1:0] a_man,
    input  logic [TAG_W-1:0]                     a_tag,

    input  logic                                 b_valid,
    output logic                                 b_ready,
    input  logic                                 b_sign,
    input  logic                                 b_cout,
    input  logic [EXPONENT_LENGTH-1:0]           b_exp,
    input  logic [NORMALIZE_MANTISSA_LENGTH-1:0] b_man,
    input  logic [TAG_W-1:0]                     b_tag,

    output logic                                 pn_sign,
    output logic                                 pn_cout,
    output logic [EXPONENT_LENGTH-1:0]           pn_exp,
    output logic [NORMALIZE_MANTISSA_LENGTH-1:0] pn_man,
    input  logic [FORMAT_LENGTH-1:0]             pn_result,
    input  logic                                 pn_overflow,
    input  logic                                 pn_underflow,

    output logic                                 res_valid,
    input  logic                                 res_ready,
    output logic [FORMAT_LENGTH-1:0]             res_data,
    output logic                                 res_ovf,
    output logic                                 res_udf,
    output logic                                 res_src,
    output logic [TAG_W-1:0]                     res_tag,

    input  logic                                 cnt_clr,
    output logic [CNT_W-1:0]                     ovf_cnt,
    output logic [CNT_W-1:0]                     udf_cnt,
    output logic                                 busy
);

    localparam logic             SRC_A   = 1'b0;
    localparam logic             SRC_B   = 1'b1;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // run_en is cleared asynchronously by reset so both readies are low while rst_n is asserted
    logic                                 run_en;
    logic                                 last_grant;

    logic                                 s1_v;
    logic                                 s1_sign;
    logic                                 s1_cout;
    logic [EXPONENT_LENGTH-1:0]           s1_exp;
    logic [NORMALIZE_MANTISSA_LENGTH-1:0] s1_man;
    logic [TAG_W-1:0]                     s1_tag;
    logic                                 s1_src;

    logic                                 s2_v;
    logic [FORMAT_LENGTH-1:0]             s2_data;
    logic                                 s2_ovf;
    logic                                 s2_udf;
    logic                                 s2_src;
    logic [TAG_W-1:0]                     s2_tag;

    logic s2_adv;
    logic s1_adv;
    logic accept_en;
    logic grant_a;
    logic grant_b;
    logic a_fire;
    logic b_fire;
    logic push;

    always_comb begin
        s2_adv    = !s2_v | res_ready;
        s1_adv    = s1_v & s2_adv;
        accept_en = run_en & (!s1_v | s2_adv);
        grant_a   = a_valid & (!b_valid | (last_grant == SRC_B));
        grant_b   = b_valid & !grant_a;
        a_ready   = accept_en & grant_a;
        b_ready   = accept_en & grant_b;
        a_fire    = a_ready;
        b_fire    = b_ready;
        push      = a_fire | b_fire;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_en     <= 1'b0;
            last_grant <= SRC_B;
        end else begin
            run_en <= 1'b1;
            if (a_fire) begin
                last_grant <= SRC_A;
            end else if (b_fire) begin
                last_grant <= SRC_B;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v    <= 1'b0;
            s1_sign <= 1'b0;
            s1_cout <= 1'b0;
            s1_exp  <= '0;
            s1_man  <= '0;
            s1_tag  <= '0;
            s1_src  <= SRC_A;
        end else if (accept_en) begin
            s1_v <= push;
            if (push) begin
                s1_sign <= a_fire ? a_sign : b_sign;
                s1_cout <= a_fire ? a_cout : b_cout;
                s1_exp  <= a_fire ? a_exp  : b_exp;
                s1_man  <= a_fire ? a_man  : b_man;
                s1_tag  <= a_fire ? a_tag  : b_tag;
                s1_src  <= a_fire ? SRC_A  : SRC_B;
            end
        end
    end

    // The normalizer sees zeros whenever stage 1 is empty
    always_comb begin
        pn_sign = s1_v ? s1_sign : 1'b0;
        pn_cout = s1_v ? s1_cout : 1'b0;
        pn_exp  = s1_v ? s1_exp  : '0;
        pn_man  = s1_v ? s1_man  : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_v    <= 1'b0;
            s2_data <= '0;
            s2_ovf  <= 1'b0;
            s2_udf  <= 1'b0;
            s2_src  <= SRC_A;
            s2_tag  <= '0;
        end else if (s2_adv) begin
            s2_v <= s1_v;
            if (s1_v) begin
                s2_data <= pn_result;
                s2_ovf  <= pn_overflow;
                s2_udf  <= pn_underflow;
                s2_src  <= s1_src;
                s2_tag  <= s1_tag;
            end
        end
    end

    always_comb begin
        res_valid = s2_v;
        res_data  = s2_data;
        res_ovf   = s2_ovf;
        res_udf   = s2_udf;
        res_src   = s2_src;
        res_tag   = s2_tag;
        busy      = s1_v | s2_v;
    end

    // Clear takes priority over a same-cycle increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_cnt <= '0;
            udf_cnt <= '0;
        end else if (cnt_clr) begin
            ovf_cnt <= '0;
            udf_cnt <= '0;
        end else begin
            if (s1_adv && pn_overflow && (ovf_cnt != CNT_MAX)) begin
                ovf_cnt <= ovf_cnt + CNT_W'(1);
            end
            if (s1_adv && pn_underflow && (udf_cnt != CNT_MAX)) begin
                udf_cnt <= udf_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_fpu_norm_arbiter.sv
// Self-checking bench for fpu_norm_arbiter: a stub normalizer drives pn_result/flags and an
// in-bench transaction queue predicts handshakes, result order, latency and counters.
module tb_fpu_norm_arbiter;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [23:0] man;
        logic        cout;
        logic [3:0]  tag;
    } op_t;

    typedef struct {
        logic [31:0] data;
        logic        ovf;
        logic        udf;
        logic        src;
        logic [3:0]  tag;
        bit          captured;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        a_valid = 1'b0, b_valid = 1'b0;
    logic        a_ready, b_ready;
    op_t         a_op = '0, b_op = '0;
    logic        pn_sign, pn_cout;
    logic [7:0]  pn_exp;
    logic [23:0] pn_man;
    logic [31:0] pn_result;
    logic        pn_overflow, pn_underflow;
    logic        force_ovf = 1'b0;
    logic        res_valid, res_ready = 1'b0;
    logic [31:0] res_data;
    logic        res_ovf, res_udf, res_src;
    logic [3:0]  res_tag;
    logic        cnt_clr = 1'b0;
    logic [7:0]  ovf_cnt, udf_cnt;
    logic        busy;

    int n_checks = 0;
    int n_err    = 0;

    exp_t       mq[$];
    bit         m_last;
    bit         m_run;
    bit         m_acc_a, m_acc_b;
    logic [7:0] m_ovf, m_udf;

    always #5 clk = ~clk;

    // Stub normalizer: sign, carry-adjusted exponent, 23-bit fraction
    assign pn_result    = {pn_sign, pn_exp ^ {7'd0, pn_cout}, pn_man[22:0]};
    assign pn_overflow  = force_ovf | (pn_exp[7:5] == 3'b111);
    assign pn_underflow = (pn_man[1:0] == 2'b11) && (pn_exp[7:4] == 4'h0);

    fpu_norm_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_ready(a_ready), .a_sign(a_op.sign), .a_cout(a_op.cout),
        .a_exp(a_op.exp), .a_man(a_op.man), .a_tag(a_op.tag),
        .b_valid(b_valid), .b_ready(b_ready), .b_sign(b_op.sign), .b_cout(b_op.cout),
        .b_exp(b_op.exp), .b_man(b_op.man), .b_tag(b_op.tag),
        .pn_sign(pn_sign), .pn_cout(pn_cout), .pn_exp(pn_exp), .pn_man(pn_man),
        .pn_result(pn_result), .pn_overflow(pn_overflow), .pn_underflow(pn_underflow),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_ovf(res_ovf), .res_udf(res_udf), .res_src(res_src), .res_tag(res_tag),
        .cnt_clr(cnt_clr), .ovf_cnt(ovf_cnt), .udf_cnt(udf_cnt), .busy(busy)
    );

    function automatic op_t rand_op();
        op_t o;
        o.sign = 1'($urandom);
        o.exp  = 8'($urandom);
        o.man  = 24'($urandom);
        o.cout = 1'($urandom);
        o.tag  = 4'($urandom);
        return o;
    endfunction

    function automatic exp_t predict(op_t op, logic src, logic fo);
        exp_t e;
        e.data     = {op.sign, 8'(op.exp ^ 8'(op.cout)), op.man[22:0]};
        e.ovf      = fo | (op.exp >= 8'he0);
        e.udf      = (op.man[0] && op.man[1]) && (op.exp < 8'h10);
        e.src      = src;
        e.tag      = op.tag;
        e.captured = 1'b0;
        return e;
    endfunction

    // Pipeline holds at most two ops; a third is refused only while output is blocked
    function automatic bit can_accept();
        return m_run && rst_n && !(mq.size() == 2 && !res_ready);
    endfunction

    function automatic bit exp_a_rdy();
        return can_accept() && a_valid && (!b_valid || m_last);
    endfunction

    function automatic bit exp_b_rdy();
        return can_accept() && b_valid && !(a_valid && (!b_valid || m_last));
    endfunction

    function automatic bit exp_res_valid();
        return mq.size() > 0 && mq[0].captured;
    endfunction

    task automatic reset_model();
        mq.delete();
        m_last  = 1'b1;
        m_run   = 1'b0;
        m_acc_a = 1'b0;
        m_acc_b = 1'b0;
        m_ovf   = 8'd0;
        m_udf   = 8'd0;
    endtask

    task automatic tick();
        bit   acc_a, acc_b, pop;
        exp_t e;
        acc_a = exp_a_rdy();
        acc_b = exp_b_rdy();
        pop   = exp_res_valid() && res_ready;
        @(posedge clk);
        if (pop) e = mq.pop_front();
        if (mq.size() > 0 && !mq[0].captured) begin
            e = mq[0];
            e.captured = 1'b1;
            mq[0] = e;
            if (e.ovf && m_ovf != 8'hff) m_ovf = m_ovf + 8'd1;
            if (e.udf && m_udf != 8'hff) m_udf = m_udf + 8'd1;
        end
        if (cnt_clr) begin
            m_ovf = 8'd0;
            m_udf = 8'd0;
        end
        if (acc_a) begin
            mq.push_back(predict(a_op, 1'b0, force_ovf));
            m_last = 1'b0;
        end else if (acc_b) begin
            mq.push_back(predict(b_op, 1'b1, force_ovf));
            m_last = 1'b1;
        end
        m_acc_a = acc_a;
        m_acc_b = acc_b;
        m_run   = rst_n;
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        a_valid   = 1'b0;
        b_valid   = 1'b0;
        res_ready = 1'b0;
        cnt_clr   = 1'b0;
        force_ovf = 1'b0;
        rst_n     = 1'b0;
        reset_model();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        reset_model();
        a_valid = 1'b1;
        b_valid = 1'b1;
        a_op = rand_op();
        b_op = rand_op();
        repeat (3) @(negedge clk);
        n_checks++;
        if (a_ready !== 1'b0 || b_ready !== 1'b0 || res_valid !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_hs: a_ready=%b b_ready=%b res_valid=%b busy=%b, expected all 0",
                     a_ready, b_ready, res_valid, busy);
        end
        n_checks++;
        if (ovf_cnt !== 8'd0 || udf_cnt !== 8'd0 || pn_exp !== 8'd0 || pn_man !== 24'd0) begin
            n_err++;
            $display("FAIL reset_regs: ovf=%0d udf=%0d pn_exp=%h pn_man=%h, expected 0",
                     ovf_cnt, udf_cnt, pn_exp, pn_man);
        end
        a_valid = 1'b0;
        b_valid = 1'b0;
        rst_n   = 1'b1;
        tick();
    endtask

    task automatic test_a_only();
        a_op = '{sign: 1'b0, exp: 8'h50, man: 24'hf6500f, cout: 1'b0, tag: 4'd3};
        a_valid   = 1'b1;
        b_valid   = 1'b0;
        res_ready = 1'b1;
        #1;
        n_checks++;
        if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
            n_err++;
            $display("FAIL a_only_ready: a_ready=%b b_ready=%b, expected 1 0", a_ready, b_ready);
        end
        tick();
        a_valid = 1'b0;
        #1;
        n_checks++;
        if (res_valid !== 1'b0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL a_only_lat1: res_valid=%b busy=%b, expected 0 1", res_valid, busy);
        end
        tick();
        n_checks++;
        if (res_valid !== 1'b1 || res_src !== 1'b0 || res_tag !== 4'd3 || res_data !== 32'h2876500f) begin
            n_err++;
            $display("FAIL a_only_result: valid=%b src=%b tag=%0d data=%h, expected 1 0 3 2876500f",
                     res_valid, res_src, res_tag, res_data);
        end
        tick();
        n_checks++;
        if (res_valid !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL a_only_drain: res_valid=%b busy=%b, expected 0 0", res_valid, busy);
        end
    endtask

    task automatic test_alternate();
        do_reset();
        res_ready = 1'b1;
        a_op = rand_op();
        b_op = rand_op();
        a_valid = 1'b1;
        b_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i == 6) begin
                a_valid = 1'b0;
                b_valid = 1'b0;
            end
            #1;
            if (i < 6) begin
                n_checks++;
                if (a_ready !== (i % 2 == 0) || b_ready !== (i % 2 == 1)) begin
                    n_err++;
                    $display("FAIL alt_grant %0d: a_ready=%b b_ready=%b, expected %b %b",
                             i, a_ready, b_ready, (i % 2 == 0), (i % 2 == 1));
                end
            end
            if (i >= 2) begin
                n_checks++;
                if (res_valid !== 1'b1 || res_src !== 1'(i % 2) || mq.size() == 0 ||
                    res_data !== mq[0].data || res_tag !== mq[0].tag) begin
                    n_err++;
                    $display("FAIL alt_result %0d: valid=%b src=%b data=%h, expected 1 %0d model head",
                             i, res_valid, res_src, res_data, i % 2);
                end
            end
            tick();
            if (m_acc_a) a_op = rand_op();
            if (m_acc_b) b_op = rand_op();
        end
        n_checks++;
        if (res_valid !== 1'b0 || mq.size() != 0) begin
            n_err++;
            $display("FAIL alt_drain: res_valid=%b model_left=%0d, expected 0 0", res_valid, mq.size());
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] held;
        int pops;
        do_reset();
        a_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            a_op = rand_op();
            #1;
            n_checks++;
            if (a_ready !== 1'b1) begin
                n_err++;
                $display("FAIL bp_accept %0d: a_ready=%b, expected 1", i, a_ready);
            end
            tick();
        end
        a_op = rand_op();
        b_op = rand_op();
        b_valid = 1'b1;
        held = mq[0].data;
        for (int k = 0; k < 4; k++) begin
            #1;
            n_checks++;
            if (a_ready !== 1'b0 || b_ready !== 1'b0 || res_valid !== 1'b1 || res_data !== held) begin
                n_err++;
                $display("FAIL bp_hold %0d: a_ready=%b b_ready=%b valid=%b data=%h, expected 0 0 1 %h",
                         k, a_ready, b_ready, res_valid, res_data, held);
            end
            tick();
        end
        b_valid   = 1'b0;
        res_ready = 1'b1;
        #1;
        n_checks++;
        if (a_ready !== 1'b1) begin
            n_err++;
            $display("FAIL bp_pop_push: a_ready=%b, expected 1", a_ready);
        end
        pops = 0;
        for (int k = 0; k < 6; k++) begin
            n_checks++;
            if (res_valid !== exp_res_valid() ||
                (exp_res_valid() && (res_data !== mq[0].data || res_tag !== mq[0].tag))) begin
                n_err++;
                $display("FAIL bp_release %0d: valid=%b data=%h, expected valid=%b",
                         k, res_valid, res_data, exp_res_valid());
            end
            if (exp_res_valid()) pops++;
            tick();
            a_valid = 1'b0;
            #1;
        end
        n_checks++;
        if (pops != 3 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL bp_count: delivered=%0d busy=%b, expected 3 0", pops, busy);
        end
    endtask

    task automatic test_counter_sat();
        do_reset();
        force_ovf = 1'b1;
        res_ready = 1'b1;
        a_valid   = 1'b1;
        for (int k = 0; k < 262; k++) begin
            a_op = rand_op();
            tick();
        end
        a_valid = 1'b0;
        repeat (3) tick();
        n_checks++;
        if (ovf_cnt !== 8'd255) begin
            n_err++;
            $display("FAIL ovf_saturate: ovf_cnt=%0d, expected 255", ovf_cnt);
        end
        a_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            a_op = rand_op();
            tick();
        end
        cnt_clr = 1'b1;
        a_op = rand_op();
        tick();
        cnt_clr = 1'b0;
        n_checks++;
        if (ovf_cnt !== 8'd0) begin
            n_err++;
            $display("FAIL ovf_clr_wins: ovf_cnt=%0d, expected 0", ovf_cnt);
        end
        a_op = rand_op();
        tick();
        n_checks++;
        if (ovf_cnt !== 8'd1) begin
            n_err++;
            $display("FAIL ovf_after_clr: ovf_cnt=%0d, expected 1", ovf_cnt);
        end
        a_valid = 1'b0;
        repeat (3) tick();
        force_ovf = 1'b0;
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 500; c++) begin
            if (!a_valid || m_acc_a) begin
                a_valid = ($urandom % 3) != 0;
                a_op = rand_op();
            end else if ($urandom % 8 == 0) begin
                a_valid = 1'b0;
            end
            if (!b_valid || m_acc_b) begin
                b_valid = ($urandom % 3) != 0;
                b_op = rand_op();
            end else if ($urandom % 8 == 0) begin
                b_valid = 1'b0;
            end
            res_ready = ($urandom % 4) != 0;
            cnt_clr   = ($urandom % 60) == 0;
            #1;
            n_checks++;
            if (a_ready !== exp_a_rdy() || b_ready !== exp_b_rdy()) begin
                n_err++;
                $display("FAIL rand_ready %0d: a=%b b=%b, expected a=%b b=%b",
                         c, a_ready, b_ready, exp_a_rdy(), exp_b_rdy());
            end
            n_checks++;
            if (res_valid !== exp_res_valid() || busy !== (mq.size() > 0)) begin
                n_err++;
                $display("FAIL rand_valid %0d: res_valid=%b busy=%b, expected %b %b",
                         c, res_valid, busy, exp_res_valid(), mq.size() > 0);
            end
            if (exp_res_valid()) begin
                n_checks++;
                if (res_data !== mq[0].data || res_ovf !== mq[0].ovf || res_udf !== mq[0].udf ||
                    res_src !== mq[0].src || res_tag !== mq[0].tag) begin
                    n_err++;
                    $display("FAIL rand_result %0d: data=%h o=%b u=%b src=%b tag=%0d, expected %h %b %b %b %0d",
                             c, res_data, res_ovf, res_udf, res_src, res_tag,
                             mq[0].data, mq[0].ovf, mq[0].udf, mq[0].src, mq[0].tag);
                end
            end
            n_checks++;
            if (ovf_cnt !== m_ovf || udf_cnt !== m_udf) begin
                n_err++;
                $display("FAIL rand_counters %0d: ovf=%0d udf=%0d, expected %0d %0d",
                         c, ovf_cnt, udf_cnt, m_ovf, m_udf);
            end
            tick();
        end
        a_valid = 1'b0;
        b_valid = 1'b0;
        cnt_clr = 1'b0;
        res_ready = 1'b1;
        repeat (3) tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        a_valid = 1'b1;
        for (int k = 0; k < 2; k++) begin
            a_op = rand_op();
            tick();
        end
        #1;
        n_checks++;
        if (res_valid !== 1'b1 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL mid_full: res_valid=%b busy=%b, expected 1 1", res_valid, busy);
        end
        #1;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (res_valid !== 1'b0 || busy !== 1'b0 || a_ready !== 1'b0) begin
            n_err++;
            $display("FAIL mid_reset: res_valid=%b busy=%b a_ready=%b, expected 0 0 0",
                     res_valid, busy, a_ready);
        end
        reset_model();
        @(negedge clk);
        a_valid = 1'b0;
        rst_n   = 1'b1;
        tick();
        a_valid   = 1'b1;
        b_valid   = 1'b1;
        res_ready = 1'b1;
        a_op = rand_op();
        b_op = rand_op();
        #1;
        n_checks++;
        if (a_ready !== 1'b1 || b_ready !== 1'b0 || res_valid !== 1'b0) begin
            n_err++;
            $display("FAIL mid_tie_a: a_ready=%b b_ready=%b res_valid=%b, expected 1 0 0",
                     a_ready, b_ready, res_valid);
        end
        tick();
        a_valid = 1'b0;
        b_valid = 1'b0;
        repeat (3) tick();
    endtask

    initial begin
        test_reset();
        test_a_only();
        test_alternate();
        test_backpressure();
        test_counter_sat();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
